// File: rtl/mem_arbiter_if.sv
// Bus bundle joining the fetch port, the data port and the shared single-port memory.
// The arbiter takes the slave view; the surrounding system takes the master view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch / data memory) in front of one single-port memory.
// Data accesses have priority; a saturating counter bounds how long a waiting fetch starves.
module mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          ref_clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [SW-1:0] starve_cnt_r;
    logic          sel_if_s;
    logic          sel_dm_s;
    logic          if_gnt_s;
    logic          dm_gnt_s;
    logic          mem_req_r;
    logic          mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic          if_rvalid_r;
    logic          dm_rvalid_r;
    logic [DW-1:0] if_rdata_r;
    logic [DW-1:0] dm_rdata_r;

    // Winner selection: data wins unless a fetch has used up its starvation budget.
    always_comb begin
        sel_if_s = 1'b0;
        sel_dm_s = 1'b0;
        if (bus.if_req && (!bus.dm_req || (starve_cnt_r == STARVE_MAX))) begin
            sel_if_s = 1'b1;
        end else if (bus.dm_req) begin
            sel_dm_s = 1'b1;
        end else begin
            sel_if_s = 1'b0;
            sel_dm_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (sel_if_s) begin
                    state_nxt_s = BUSY_IF;
                end else if (sel_dm_s) begin
                    state_nxt_s = BUSY_DM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (bus.mem_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: grants are combinational and only ever offered from IDLE.
    always_comb begin
        if_gnt_s = 1'b0;
        dm_gnt_s = 1'b0;
        if ((state_r == IDLE) && !reset) begin
            if_gnt_s = sel_if_s;
            dm_gnt_s = sel_dm_s;
        end else begin
            if_gnt_s = 1'b0;
            dm_gnt_s = 1'b0;
        end
    end

    // Memory command capture on grant, and read data / completion pulses on mem_ready.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            if_rvalid_r <= 1'b0;
            dm_rvalid_r <= 1'b0;
            if_rdata_r  <= {DW{1'b0}};
            dm_rdata_r  <= {DW{1'b0}};
        end else begin
            if_rvalid_r <= 1'b0;
            dm_rvalid_r <= 1'b0;
            if (if_gnt_s) begin
                mem_req_r   <= 1'b1;
                mem_we_r    <= 1'b0;
                mem_addr_r  <= bus.if_addr;
                mem_wdata_r <= {DW{1'b0}};
            end else if (dm_gnt_s) begin
                mem_req_r   <= 1'b1;
                mem_we_r    <= bus.dm_we;
                mem_addr_r  <= bus.dm_addr;
                mem_wdata_r <= bus.dm_wdata;
            end else if ((state_r != IDLE) && bus.mem_ready) begin
                mem_req_r <= 1'b0;
                if (state_r == BUSY_IF) begin
                    if_rvalid_r <= 1'b1;
                    if_rdata_r  <= bus.mem_rdata;
                end else begin
                    dm_rvalid_r <= 1'b1;
                    // Write completions leave the last read value untouched.
                    if (!mem_we_r) begin
                        dm_rdata_r <= bus.mem_rdata;
                    end else begin
                        dm_rdata_r <= dm_rdata_r;
                    end
                end
            end else begin
                mem_req_r <= mem_req_r;
            end
        end
    end

    // Consecutive data grants taken while a fetch was waiting, saturating.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (if_gnt_s) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (dm_gnt_s) begin
            if (!bus.if_req) begin
                starve_cnt_r <= {SW{1'b0}};
            end else if (starve_cnt_r == STARVE_MAX) begin
                starve_cnt_r <= starve_cnt_r;
            end else begin
                starve_cnt_r <= starve_cnt_r + SW'(1);
            end
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign bus.if_gnt    = if_gnt_s;
    assign bus.dm_gnt    = dm_gnt_s;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.if_rvalid = if_rvalid_r;
    assign bus.dm_rvalid = dm_rvalid_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.dm_rdata  = dm_rdata_r;
endmodule
